// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Request/result bundle for the bit-serial adder. The master
//               side issues start plus operands. The slave side returns
//               status and the registered result.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : LSB-first bit-serial adder. It handles one full-adder bit per
//               clock and keeps the carry in a 1-bit register. A result
//               appears in WIDTH+1 cycles after an accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  serial_adder_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_add  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic               w_bit;
  logic               w_carry_next;
  logic [WIDTH-1:0]   w_sum_next;

  // A start is only honoured when no addition is in flight.
  assign w_accept     = bus.start && ((r_state == c_idle) || (r_state == c_done));
  assign w_last       = (r_cnt == c_last_cnt);
  assign w_bit        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  // The new sum bit enters at the MSB end, so after WIDTH shifts bit i sits at position i.
  assign w_sum_next   = {w_bit, r_sum_sh[WIDTH-1:1]};

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. DONE can chain directly into a new ADD when start is high.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  w_next_state = bus.start ? c_add : c_idle;
      c_add:   w_next_state = w_last ? c_done : c_add;
      c_done:  w_next_state = bus.start ? c_add : c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Status outputs are decoded from the registered state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      c_add:   bus.busy = 1'b1;
      c_done:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per ADD cycle, and commit the result on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_s      <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == c_add) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_next;
      r_carry  <= w_carry_next;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_s    <= w_sum_next;
        r_cout <= w_carry_next;
      end
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. It runs directed and
//               random additions at WIDTH=8 and an exhaustive sweep at
//               WIDTH=4. Results are checked against plain integer addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] prev_s;
  logic       prev_cout;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic log_fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Run one WIDTH=8 addition. Operand noise and a stray start are injected while busy.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] e_sum;
    e_sum = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (bus8.busy !== 1'b1) log_fail("busy8", bus8.busy, 1'b1);
      n_tests++;
      if (bus8.done !== 1'b0) log_fail("done_low8", bus8.done, 1'b0);
      n_tests++;
      if ({bus8.cout, bus8.s} !== {prev_cout, prev_s})
        log_fail("s_hold8", {bus8.cout, bus8.s}, {prev_cout, prev_s});
      bus8.start = (i == 3);
      bus8.a = 8'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    n_tests++;
    if (bus8.done !== 1'b1) log_fail("done8", bus8.done, 1'b1);
    n_tests++;
    if (bus8.busy !== 1'b0) log_fail("busy_low8", bus8.busy, 1'b0);
    n_tests++;
    if (bus8.s !== e_sum[7:0]) log_fail("sum8", bus8.s, e_sum[7:0]);
    n_tests++;
    if (bus8.cout !== e_sum[8]) log_fail("cout8", bus8.cout, e_sum[8]);
    prev_s    = e_sum[7:0];
    prev_cout = e_sum[8];
  endtask

  // Run one WIDTH=4 addition. Done must land exactly 5 cycles after the start edge.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] e_sum;
    logic       busy_ok;
    e_sum   = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    busy_ok = 1'b1;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
    @(negedge clk);
    bus4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      busy_ok = busy_ok & bus4.busy & ~bus4.done;
      @(negedge clk);
    end
    n_tests++;
    if (busy_ok !== 1'b1) log_fail("busy4", busy_ok, 1'b1);
    n_tests++;
    if (bus4.done !== 1'b1) log_fail("done4", bus4.done, 1'b1);
    n_tests++;
    if ({bus4.cout, bus4.s} !== e_sum) log_fail("sum4", {bus4.cout, bus4.s}, e_sum);
  endtask

  // Directed and random stimulus, run as one linear sequence.
  initial begin
    int  cnt;
    logic quiet_ok;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    prev_s = 8'h00; prev_cout = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus8.busy !== 1'b0) log_fail("rst_busy", bus8.busy, 1'b0);
    n_tests++;
    if (bus8.done !== 1'b0) log_fail("rst_done", bus8.done, 1'b0);
    n_tests++;
    if (bus8.s !== 8'h00) log_fail("rst_s", bus8.s, 8'h00);
    n_tests++;
    if (bus8.cout !== 1'b0) log_fail("rst_cout", bus8.cout, 1'b0);
    rst_n = 1'b1;

    // Directed cases
    run8(8'h3C, 8'h42, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1);
    run8(8'h00, 8'h00, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);

    // Random cases
    for (int n = 0; n < 30; n++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Start held high: a result every 9 cycles via DONE -> ADD
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
    cnt = 0;
    while (!bus8.done && cnt < 20) begin @(negedge clk); cnt++; end
    n_tests++;
    if (cnt != 9) log_fail("b2b_first_lat", cnt, 9);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      cnt = 1;
      while (!bus8.done && cnt < 20) begin @(negedge clk); cnt++; end
      n_tests++;
      if (cnt != 9) log_fail("b2b_period", cnt, 9);
      n_tests++;
      if (bus8.s !== 8'h02) log_fail("b2b_s", bus8.s, 8'h02);
      n_tests++;
      if (bus8.cout !== 1'b0) log_fail("b2b_cout", bus8.cout, 1'b0);
    end
    bus8.start = 1'b0;
    prev_s = 8'h02; prev_cout = 1'b0;

    // Reset mid-ADD aborts the addition and clears the result
    run8(8'h3C, 8'h42, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h11; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus8.busy !== 1'b0) log_fail("arst_busy", bus8.busy, 1'b0);
    n_tests++;
    if (bus8.done !== 1'b0) log_fail("arst_done", bus8.done, 1'b0);
    n_tests++;
    if (bus8.s !== 8'h00) log_fail("arst_s", bus8.s, 8'h00);
    n_tests++;
    if (bus8.cout !== 1'b0) log_fail("arst_cout", bus8.cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      quiet_ok = quiet_ok & ~bus8.done & ~bus8.busy;
      @(negedge clk);
    end
    n_tests++;
    if (quiet_ok !== 1'b1) log_fail("arst_no_done", quiet_ok, 1'b1);
    prev_s = 8'h00; prev_cout = 1'b0;
    run8(8'h55, 8'h11, 1'b0);

    // Operand changes without start leave the result untouched
    quiet_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      quiet_ok = quiet_ok & ~bus8.done & ~bus8.busy
                 & (bus8.s === prev_s) & (bus8.cout === prev_cout);
    end
    n_tests++;
    if (quiet_ok !== 1'b1) log_fail("idle_hold", quiet_ok, 1'b1);

    // Exhaustive sweep at WIDTH=4
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run4(4'(ai), 4'(bi), 1'(ci));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request: capture operands and begin an addition.
REQ-005 a  input  WIDTH  operand A, sampled only on accepted start.
REQ-006 b  input  WIDTH  operand B, sampled only on accepted start.
REQ-007 cin  input  1  carry-in, sampled only on accepted start.
REQ-008 busy  output  1  high while the block is adding bits.
REQ-009 done  output  1  one-cycle pulse: result valid and just updated.
REQ-010 s  output  WIDTH  registered sum of last completed addition.
REQ-011 cout  output  1  registered carry-out of last completed addition.

Function
REQ-012 The block SHALL be an LSB-first bit-serial adder: one full-adder bit operation per clock plus a 1-bit carry register.
REQ-013 FSM states SHALL be IDLE, ADD, DONE; encoding is free.
REQ-014 IDLE: start=1 SHALL load the A shift reg from a, the B shift reg from b, the carry reg from cin, and the bit counter to 0, then go to ADD; start=0 stays in IDLE.
REQ-015 ADD: each cycle SHALL compute bit = A[0]^B[0]^carry and carry_next = (A[0]&B[0])|(carry&(A[0]^B[0])), then shift A and B right by one.
REQ-016 ADD: the sum bit SHALL shift into the sum shift reg from the MSB end, so after WIDTH cycles bit i sits at position i.
REQ-017 ADD: the counter SHALL increment each cycle; on the cycle with counter==WIDTH-1 the next state SHALL be DONE.
REQ-018 On the edge entering DONE, s SHALL load the completed sum and cout SHALL load the final carry.
REQ-019 s and cout SHALL hold their values at all other times, including during a following ADD.
REQ-020 busy SHALL be high exactly in ADD and done high exactly in DONE; both SHALL be decoded from registered state.
REQ-021 Latency: with start sampled at edge k, busy SHALL be high for cycles k+1..k+WIDTH and done high for exactly cycle k+WIDTH+1.
REQ-022 DONE SHALL last one cycle; start=1 in DONE SHALL be accepted like in IDLE (back-to-back, next state ADD), otherwise next state is IDLE.
REQ-023 start during ADD SHALL be ignored; operands, carry and the counter SHALL NOT be disturbed.
REQ-024 Changes on a, b, cin outside an accepted start SHALL have no effect.
REQ-025 Result SHALL equal a + b + cin modulo 2^WIDTH in s, with bit WIDTH of the true sum in cout, for all inputs.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE and clear busy, done, s, cout, counter, carry and all shift regs to 0, regardless of clk.
REQ-027 Reset asserted mid-ADD SHALL abort the operation with no done pulse; s and cout SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-029 a=0x3C, b=0x42, cin=0, start pulse -> busy for 8 cycles, then done for 1 cycle with s=0x7E, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; then a=0xA5, b=0x5A, cin=1 -> s=0x00, cout=1.
REQ-031 start held high continuously with a=0x01, b=0x01, cin=0 -> done every 9 cycles (back-to-back via DONE), each time s=0x02, cout=0; start pulses during busy cause no restart.
REQ-032 Mid-ADD (cycle 4) drive rst_n=0 -> busy, done, s, cout go 0 asynchronously; no done follows; a new start after release completes correctly.
REQ-033 WIDTH=4: exhaustive sweep of all a, b, cin (512 cases) -> {cout,s} == a+b+cin for every case, and each done falls exactly 5 cycles after its start edge.
REQ-034 After a completed add, change a/b/cin without start -> s, cout unchanged and no done pulse.
